// File: rtl/ipcu_arbiter_if.sv
// Handshake bundle between the IPCU requesters and the shared-pipe arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface ipcu_arbiter_if #(
    parameter int N_PORTS = 4,
    parameter int ID_W    = 2
);
    logic [N_PORTS-1:0] rqs_strobe;
    logic [N_PORTS-1:0] wr_strobe;
    logic [N_PORTS-1:0] rd_strobe;
    logic [N_PORTS-1:0] arb_ack;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic               timeout_err;
    logic               proto_err;

    modport master (
        output rqs_strobe, wr_strobe, rd_strobe,
        input  arb_ack, grant_id, busy, timeout_err, proto_err
    );

    modport slave (
        input  rqs_strobe, wr_strobe, rd_strobe,
        output arb_ack, grant_id, busy, timeout_err, proto_err
    );
endinterface

// File: rtl/ipcu_arbiter.sv
// Round-robin arbiter granting a shared pipe to one IPCU at a time.
// A grant ends on the owner's first wr/rd strobe or after TIMEOUT idle
// cycles, followed by one dead GAP cycle so ack never moves owner-to-owner.
module ipcu_arbiter #(
    parameter int N_PORTS = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    ipcu_arbiter_if.slave bus
);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [N_PORTS-1:0] pend_q, pend_d;
    logic [N_PORTS-1:0] ack_q, ack_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               terr_q, terr_d;
    logic               perr_q, perr_d;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    cand;
    logic [N_PORTS-1:0] pend_clr;
    logic               owner_done;

    // Round-robin pick: first pending port after the last winner, wrapping.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            cand = ID_W'((int'(last_q) + k) % N_PORTS);
            if (!win_found && pend_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state, pending and registered-output logic for the grant FSM.
    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        gid_d      = gid_q;
        last_d     = last_q;
        timer_d    = timer_q;
        terr_d     = 1'b0;
        pend_clr   = '0;
        owner_done = 1'b0;
        // Any transfer strobe from a port not holding ack is a protocol error.
        perr_d     = |((bus.wr_strobe | bus.rd_strobe) & ~ack_q);

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    ack_d    = N_PORTS'(1) << win_idx;
                    pend_clr = N_PORTS'(1) << win_idx;
                    gid_d    = win_idx;
                    last_d   = win_idx;
                    timer_d  = '0;
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                owner_done = bus.wr_strobe[gid_q] | bus.rd_strobe[gid_q];
                timer_d    = timer_q + 1'b1;
                // Completion takes priority over a timeout on the same edge.
                if (owner_done) begin
                    ack_d   = '0;
                    state_d = S_GAP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    ack_d   = '0;
                    terr_d  = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                ack_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // A new request wins over the grant clearing the same bit.
        pend_d = (pend_q & ~pend_clr) | bus.rqs_strobe;
    end

    // State and output registers; async reset drops ack immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: pend/timer are control state and must reset; a plain data memory would not need to.
            state_q <= S_IDLE;
            pend_q  <= '0;
            ack_q   <= '0;
            gid_q   <= '0;
            last_q  <= ID_W'(N_PORTS - 1);
            timer_q <= '0;
            terr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            terr_q  <= terr_d;
            perr_q  <= perr_d;
        end
    end

    assign bus.arb_ack     = ack_q;
    assign bus.grant_id    = gid_q;
    assign bus.busy        = |ack_q;
    assign bus.timeout_err = terr_q;
    assign bus.proto_err   = perr_q;

endmodule

// File: tb/tb_ipcu_arbiter.sv
// Directed bench for ipcu_arbiter: reset, single grant, round-robin order,
// timeout, protocol errors, completion/timeout collision and async reset.
module tb_ipcu_arbiter;
    localparam int N_PORTS = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    ipcu_arbiter_if #(.N_PORTS(N_PORTS), .ID_W(ID_W)) bus ();

    ipcu_arbiter #(.N_PORTS(N_PORTS), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] rqs, input logic [3:0] wr, input logic [3:0] rd);
        bus.rqs_strobe = rqs;
        bus.wr_strobe  = wr;
        bus.rd_strobe  = rd;
        tick();
        bus.rqs_strobe = '0;
        bus.wr_strobe  = '0;
        bus.rd_strobe  = '0;
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] ack, input logic [1:0] gid);
        check({tag, "/ack"}, 32'(bus.arb_ack), 32'(ack));
        check({tag, "/busy"}, 32'(bus.busy), 32'(|ack));
        check({tag, "/gid"}, 32'(bus.grant_id), 32'(gid));
    endtask

    initial begin
        rst            = 1'b0;
        bus.rqs_strobe = '0;
        bus.wr_strobe  = '0;
        bus.rd_strobe  = '0;

        // Reset held with strobes toggling: nothing visible, nothing remembered.
        for (int i = 0; i < 4; i++) begin
            bus.rqs_strobe = 4'($urandom);
            bus.wr_strobe  = 4'($urandom);
            bus.rd_strobe  = 4'($urandom);
            tick();
        end
        expect_grant("rst", 4'b0000, 2'd0);
        check("rst/terr", 32'(bus.timeout_err), 32'd0);
        check("rst/perr", 32'(bus.proto_err), 32'd0);
        bus.rqs_strobe = '0;
        bus.wr_strobe  = '0;
        bus.rd_strobe  = '0;
        rst = 1'b1;
        tick(2);
        check("rst_lost/ack", 32'(bus.arb_ack), 32'd0);

        // All four request together: grants go 0,1,2,3 with 2 ack-low cycles between.
        pulse(4'b1111, 4'b0000, 4'b0000);
        check("rr_e0/ack", 32'(bus.arb_ack), 32'd0);
        tick();
        for (int p = 0; p < 4; p++) begin
            expect_grant($sformatf("rr%0d", p), 4'(1 << p), 2'(p));
            pulse(4'b0000, 4'(1 << p), 4'b0000);
            check($sformatf("rr%0d_rel/ack", p), 32'(bus.arb_ack), 32'd0);
            check($sformatf("rr%0d_rel/perr", p), 32'(bus.proto_err), 32'd0);
            tick();
            check($sformatf("rr%0d_gap2/ack", p), 32'(bus.arb_ack), 32'd0);
            tick();
        end
        expect_grant("rr_done", 4'b0000, 2'd3);

        // Single request to port 2: ack two edges after the strobe edge.
        pulse(4'b0100, 4'b0000, 4'b0000);
        check("single_e0/ack", 32'(bus.arb_ack), 32'd0);
        tick();
        expect_grant("single", 4'b0100, 2'd2);
        pulse(4'b0000, 4'b0100, 4'b0000);
        expect_grant("single_rel", 4'b0000, 2'd2);
        tick(2);

        // Timeout on port 1 with port 3 pending behind it.
        pulse(4'b0010, 4'b0000, 4'b0000);
        tick();
        expect_grant("to_grant", 4'b0010, 2'd1);
        pulse(4'b1000, 4'b0000, 4'b0000);
        tick(14);
        check("to_g15/ack", 32'(bus.arb_ack), 32'b0010);
        check("to_g15/terr", 32'(bus.timeout_err), 32'd0);
        tick();
        check("to_g16/ack", 32'(bus.arb_ack), 32'd0);
        check("to_g16/terr", 32'(bus.timeout_err), 32'd1);
        tick();
        check("to_g17/terr", 32'(bus.timeout_err), 32'd0);
        check("to_g17/ack", 32'(bus.arb_ack), 32'd0);
        tick();
        expect_grant("to_next", 4'b1000, 2'd3);
        // Owner wr and rd together: one completion, no error.
        pulse(4'b0000, 4'b1000, 4'b1000);
        check("wr_rd/ack", 32'(bus.arb_ack), 32'd0);
        check("wr_rd/perr", 32'(bus.proto_err), 32'd0);
        tick(2);

        // Strobe from a non-owner while port 0 holds the pipe.
        pulse(4'b0001, 4'b0000, 4'b0000);
        tick();
        expect_grant("pe_grant", 4'b0001, 2'd0);
        pulse(4'b0000, 4'b0000, 4'b0100);
        check("pe/perr", 32'(bus.proto_err), 32'd1);
        check("pe/ack", 32'(bus.arb_ack), 32'b0001);
        tick();
        check("pe_after/perr", 32'(bus.proto_err), 32'd0);
        check("pe_after/ack", 32'(bus.arb_ack), 32'b0001);
        pulse(4'b0000, 4'b0001, 4'b0000);
        check("pe_rel/ack", 32'(bus.arb_ack), 32'd0);
        tick(2);
        // Strobe seen in IDLE is always a protocol error.
        pulse(4'b0000, 4'b0010, 4'b0000);
        check("pe_idle/perr", 32'(bus.proto_err), 32'd1);
        check("pe_idle/ack", 32'(bus.arb_ack), 32'd0);
        tick();
        check("pe_idle_after/perr", 32'(bus.proto_err), 32'd0);

        // Completion on the timeout cycle: completion wins.
        pulse(4'b0010, 4'b0000, 4'b0000);
        tick();
        expect_grant("coll_grant", 4'b0010, 2'd1);
        tick(15);
        check("coll_g15/ack", 32'(bus.arb_ack), 32'b0010);
        pulse(4'b0000, 4'b0010, 4'b0000);
        check("coll/ack", 32'(bus.arb_ack), 32'd0);
        check("coll/terr", 32'(bus.timeout_err), 32'd0);
        tick();
        check("coll_after/terr", 32'(bus.timeout_err), 32'd0);
        tick();

        // Async reset mid-grant: ack drops with no clock edge; pending lost.
        pulse(4'b0010, 4'b0000, 4'b0000);
        tick();
        expect_grant("ar_grant", 4'b0010, 2'd1);
        pulse(4'b0100, 4'b0000, 4'b0000);
        #3 rst = 1'b0;
        #1;
        check("ar/ack", 32'(bus.arb_ack), 32'd0);
        check("ar/busy", 32'(bus.busy), 32'd0);
        check("ar/gid", 32'(bus.grant_id), 32'd0);
        tick();
        rst = 1'b1;
        tick(3);
        check("ar_pend_cleared/ack", 32'(bus.arb_ack), 32'd0);
        // Round-robin pointer back to N-1, so port 0 beats port 2.
        pulse(4'b0101, 4'b0000, 4'b0000);
        tick();
        expect_grant("ar_first", 4'b0001, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
